// File: rtl/pll_mgr_pkg.sv
// Shared definitions for the PLL lock manager: FSM states, default
// parameter values and the timer-width helper.
package pll_mgr_pkg;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_RST_PULSE_CYC   = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYC = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 65536;
  localparam int unsigned DEF_MAX_RETRY       = 7;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_e;

  // One shared timer must hold the largest terminal count of any state.
  function automatic int unsigned timer_width(input int unsigned pulse_cyc,
                                              input int unsigned stable_cyc,
                                              input int unsigned timeout_cyc);
    int unsigned m;
    m = pulse_cyc;
    if (stable_cyc > m) m = stable_cyc;
    if (timeout_cyc > m) m = timeout_cyc;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Multi-stage bit synchronizer with synchronous reset to 0. Used for the
// PLL lock input here and for sys_rst in each downstream clock domain.
module lock_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_mgr.sv
// PLL reset sequencing and lock qualification on the reference clock.
// Pulses the PLL reset, waits for a qualified lock, retries on timeout,
// and releases the system reset only while lock is held in RUN.
module pll_lock_mgr
  import pll_mgr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int unsigned RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY
) (
  input  logic       clkin1,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       locked_ok,
  output logic       fail,
  output logic [7:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned TW = timer_width(RST_PULSE_CYC, LOCK_STABLE_CYC,
                                           LOCK_TIMEOUT_CYC);

  localparam logic [TW-1:0] PULSE_LAST   = TW'(RST_PULSE_CYC - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [7:0]    RETRY_LIMIT  = 8'(MAX_RETRY);

  logic          lock_s;
  pll_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          pll_rst_q, sys_rst_q, locked_ok_q, fail_q;

  lock_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk_i(clkin1),
    .rst_i(rst),
    .d_i  (pll_lock),
    .q_o  (lock_s)
  );

  // Next-state, timer and counter logic; timer clears on every transition.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      RESET_PLL: begin
        if (timer_q == PULSE_LAST) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lock_s) begin
          state_d = STABLE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          timer_d = '0;
          if (retry_q == RETRY_LIMIT) begin
            state_d = FAIL;
          end else begin
            state_d = RESET_PLL;
            retry_d = retry_q + 8'd1;
          end
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_d = RUN;
          timer_d = '0;
          retry_d = '0;
        end
      end
      RUN: begin
        timer_d = '0;
        if (!lock_s) begin
          state_d = RESET_PLL;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      FAIL: begin
        timer_d = '0;
      end
      default: begin
        state_d = RESET_PLL;
        timer_d = '0;
      end
    endcase
  end

  // State register with Moore outputs registered from the next state.
  always_ff @(posedge clkin1) begin
    if (rst) begin
      state_q     <= RESET_PLL;
      timer_q     <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_ok_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= (state_d == RESET_PLL);
      sys_rst_q   <= (state_d != RUN);
      locked_ok_q <= (state_d == RUN);
      fail_q      <= (state_d == FAIL);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst       = sys_rst_q;
  assign locked_ok     = locked_ok_q;
  assign fail          = fail_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_mgr.sv
// Self-checking bench for pll_lock_mgr with small parameters.
module tb_pll_lock_mgr;

  localparam int SYNC  = 2;
  localparam int PULSE = 4;
  localparam int STBL  = 8;
  localparam int TMO   = 32;
  localparam int MAXR  = 2;
  localparam int NREC  = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_rst, sys_rst, locked_ok, fail;
  logic [7:0] retry_cnt, lock_loss_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  pll_lock_mgr #(
    .SYNC_STAGES     (SYNC),
    .RST_PULSE_CYC   (PULSE),
    .LOCK_STABLE_CYC (STBL),
    .LOCK_TIMEOUT_CYC(TMO),
    .MAX_RETRY       (MAXR)
  ) dut (
    .clkin1       (clk),
    .rst          (rst),
    .pll_lock     (pll_lock),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .locked_ok    (locked_ok),
    .fail         (fail),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase is tracked by name with an entry timestamp; the lock seen by the
  // sequencer is the raw input delayed by SYNC samples (zeroed by reset).
  string ph = "pulse";
  int    cyc = 0, entry = 0, el = 0, m_retry = 0, m_loss = 0;
  bit    m_valid = 1'b0;
  bit    ls;
  bit    hist[$];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      ph = "pulse"; entry = cyc; m_retry = 0; m_loss = 0; m_valid = 1'b1;
      hist = {};
      for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
    end else if (m_valid) begin
      ls = hist.pop_front();
      hist.push_back(pll_lock);
      el = cyc - entry;
      if (ph == "pulse") begin
        if (el == PULSE) begin ph = "wait"; entry = cyc; end
      end else if (ph == "wait") begin
        if (ls) begin ph = "stab"; entry = cyc; end
        else if (el == TMO) begin
          entry = cyc;
          if (m_retry == MAXR) ph = "dead";
          else begin m_retry++; ph = "pulse"; end
        end
      end else if (ph == "stab") begin
        if (!ls) begin ph = "wait"; entry = cyc; end
        else if (el == STBL) begin ph = "run"; entry = cyc; m_retry = 0; end
      end else if (ph == "run") begin
        if (!ls) begin
          ph = "pulse"; entry = cyc;
          m_loss = (m_loss < 255) ? m_loss + 1 : 255;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("pll_rst",       32'(pll_rst),       32'(ph == "pulse"));
      check("sys_rst",       32'(sys_rst),       32'(ph != "run"));
      check("locked_ok",     32'(locked_ok),     32'(ph == "run"));
      check("fail",          32'(fail),          32'(ph == "dead"));
      check("retry_cnt",     32'(retry_cnt),     m_retry);
      check("lock_loss_cnt", 32'(lock_loss_cnt), m_loss);
    end
  end

  // ---------------- stimulus ----------------
  logic       rec_prst [NREC];
  logic       rec_srst [NREC];
  logic       rec_lok  [NREC];
  logic       rec_fail [NREC];
  logic [7:0] rec_retry[NREC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // mode 0: lock rises at cycle 10; mode 1: lock held low; mode 2: 5 high / 1 low.
  task automatic run_rec(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       pll_lock = (i >= 10);
        1:       pll_lock = 1'b0;
        default: pll_lock = ((i % 6) < 5);
      endcase
      tick();
      rec_prst[i]  = pll_rst;
      rec_srst[i]  = sys_rst;
      rec_lok[i]   = locked_ok;
      rec_fail[i]  = fail;
      rec_retry[i] = retry_cnt;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, cnt, mx;
    bit ok;

    // 1. Nominal bring-up
    pll_lock = 1'b0;
    do_reset(3);
    check("t1_reset_pll_rst", 32'(pll_rst), 1);
    check("t1_reset_sys_rst", 32'(sys_rst), 1);
    check("t1_reset_fail",    32'(fail), 0);
    run_rec(40, 0);
    idx = -1;
    for (int i = 0; i < 40; i++) if (idx < 0 && rec_prst[i] === 1'b0) idx = i;
    check("t1_pll_rst_fall_idx", idx, 3);
    idx = -1;
    for (int i = 0; i < 40; i++) if (idx < 0 && rec_srst[i] === 1'b0) idx = i;
    check("t1_sys_rst_fall_idx", idx, 20);
    check("t1_locked_ok", 32'(rec_lok[20]), 1);
    check("t1_retry", 32'(rec_retry[20]), 0);

    // 2. Chatter never qualifies
    pll_lock = 1'b0;
    do_reset(2);
    run_rec(150, 2);
    cnt = 0; mx = 0;
    for (int i = 0; i < 150; i++) begin
      if (rec_srst[i] !== 1'b1 || rec_lok[i] !== 1'b0) cnt++;
      if (int'(rec_retry[i]) > mx) mx = int'(rec_retry[i]);
    end
    check("t2_released_cycles", cnt, 0);
    check("t2_max_retry", mx, 0);

    // 3. Timeout, retries, terminal failure
    pll_lock = 1'b0;
    do_reset(2);
    run_rec(320, 1);
    cnt = 0;
    for (int i = 0; i < 320; i++) if (rec_prst[i] === 1'b1) cnt++;
    check("t3_pll_rst_high_total", cnt, 11);
    check("t3_pulse2_pre",   32'(rec_prst[34]), 0);
    check("t3_pulse2_start", 32'(rec_prst[35]), 1);
    check("t3_pulse2_end",   32'(rec_prst[38]), 1);
    check("t3_pulse2_post",  32'(rec_prst[39]), 0);
    check("t3_pulse3_start", 32'(rec_prst[71]), 1);
    check("t3_pulse3_post",  32'(rec_prst[75]), 0);
    check("t3_retry1", 32'(rec_retry[40]), 1);
    check("t3_retry2", 32'(rec_retry[80]), 2);
    idx = -1;
    for (int i = 0; i < 320; i++) if (idx < 0 && rec_fail[i] === 1'b1) idx = i;
    check("t3_fail_idx", idx, 107);
    cnt = 0;
    for (int i = 0; i < 320; i++) if (rec_fail[i] === 1'b1) cnt++;
    check("t3_fail_held", cnt, 213);
    check("t3_fail_sys_rst", 32'(rec_srst[319]), 1);
    check("t3_fail_pll_rst", 32'(rec_prst[319]), 0);

    // 4. Lock loss in RUN, repeated to saturation
    pll_lock = 1'b1;
    do_reset(2);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin tick(); ok = (locked_ok === 1'b1); end
    check("t4_first_run", 32'(ok), 1);
    for (int k = 0; k < 300 && ok; k++) begin
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
      cnt = 1;
      while (sys_rst !== 1'b1 && cnt < 10) begin tick(); cnt++; end
      if (k == 0) begin
        check("t4_loss_latency", cnt, SYNC + 1);
        check("t4_loss_cnt1",    32'(lock_loss_cnt), 1);
        check("t4_loss_pll_rst", 32'(pll_rst), 1);
      end
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin tick(); ok = (locked_ok === 1'b1); end
      if (k == 0 || !ok) check("t4_relock", 32'(ok), 1);
      if (k == 0) check("t4_relock_retry", 32'(retry_cnt), 0);
    end
    check("t4_loss_saturated", 32'(lock_loss_cnt), 255);

    // 5. Reset mid-pulse and reset out of FAIL
    pll_lock = 1'b0;
    do_reset(1);
    check("t5_loss_cleared", 32'(lock_loss_cnt), 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("t5_pll_rst_in_rst", 32'(pll_rst), 1);
    rst = 1'b0;
    cnt = 0;
    while (pll_rst === 1'b1 && cnt < 20) begin tick(); cnt++; end
    check("t5_full_pulse", cnt, PULSE);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin tick(); ok = (fail === 1'b1); end
    check("t5_reached_fail", 32'(ok), 1);
    rst = 1'b1;
    tick();
    check("t5_fail_cleared",  32'(fail), 0);
    check("t5_pll_rst",       32'(pll_rst), 1);
    check("t5_retry_cleared", 32'(retry_cnt), 0);
    rst = 1'b0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
